pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 88 ++++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and single-outstanding instruction fetch controller
// with execute redirects, in-flight kill, and misaligned-target trap vectoring.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        ResetN,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic        InstrValid,
  output logic [31:0] InstrOut,
  output logic [31:0] InstrPC,
  output logic [31:0] InstrPCPlus4,
  input  logic        InstrAccept,
  input  logic        RedirectValid,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  output logic        MisalignTrap
);
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d, ipc4_q, ipc4_d, tgt;
  logic kill_q, kill_d, trap_q, trap_d, redir;
  always_comb begin
    redir   = RedirectValid && (PCSrc == 2'b01 || PCSrc == 2'b10);
    tgt     = PCSrc == 2'b01 ? PCTarget : ALUResult;
    trap_d  = redir && |tgt[1:0];
    state_d = state_q;
    pc_d    = redir ? (|tgt[1:0] ? TRAP_VECTOR : tgt) : pc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: if (IMemGnt) begin
        state_d = WAIT;
        kill_d  = redir;
      end
      WAIT: if (IMemRValid) begin
        kill_d = 1'b0;
        if (kill_q || redir) state_d = REQ;
        else begin
          state_d = HOLD;
          instr_d = IMemRData;
          ipc_d   = pc_q;
          ipc4_d  = pc_q + 32'd4;
        end
      end else if (redir) kill_d = 1'b1;
      HOLD: if (redir || InstrAccept) begin
        state_d = REQ;
        if (!redir) pc_d = pc_q + 32'd4;
      end
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      kill_q  <= 1'b0;
      trap_q  <= 1'b0;
      instr_q <= 32'd0;
      ipc_q   <= 32'd0;
      ipc4_q  <= 32'd4;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      trap_q  <= trap_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
    end
  end
  assign IMemReq      = state_q == REQ;
  assign IMemAddr     = pc_q;
  assign InstrValid   = state_q == HOLD;
  assign InstrOut     = instr_q;
  assign InstrPC      = ipc_q;
  assign InstrPCPlus4 = ipc4_q;
  assign MisalignTrap = trap_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of fetch sequencing, hold, redirect/kill, trap,
// PC wrap, reserved PCSrc and mid-fetch reset.
module tb_pc_sequencer;
  logic CLK = 1'b0;
  logic ResetN = 1'b0;
  logic IMemReq, IMemGnt = 1'b1, IMemRValid = 1'b0, InstrValid, InstrAccept = 1'b1;
  logic RedirectValid = 1'b0, MisalignTrap;
  logic [1:0] PCSrc = 2'b00;
  logic [31:0] IMemAddr, IMemRData = 32'd0, InstrOut, InstrPC, InstrPCPlus4;
  logic [31:0] PCTarget = 32'd0, ALUResult = 32'd0;
  logic rst_b_n = 1'b0, req_b, rv_b = 1'b0, gr_b = 1'b0, valid_b, trap_b, redir_b = 1'b0;
  logic [31:0] addr_b, out_b, pc_b, pc4_b;
  logic rv_en = 1'b1, pend = 1'b0;
  logic [31:0] paddr = 32'd0;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  pc_sequencer u_dut (
    .CLK(CLK), .ResetN(ResetN), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemRValid(IMemRValid), .IMemRData(IMemRData), .InstrValid(InstrValid), .InstrOut(InstrOut),
    .InstrPC(InstrPC), .InstrPCPlus4(InstrPCPlus4), .InstrAccept(InstrAccept),
    .RedirectValid(RedirectValid), .PCSrc(PCSrc), .PCTarget(PCTarget), .ALUResult(ALUResult),
    .MisalignTrap(MisalignTrap)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
    .CLK(CLK), .ResetN(rst_b_n), .IMemReq(req_b), .IMemAddr(addr_b), .IMemGnt(1'b1),
    .IMemRValid(rv_b), .IMemRData(32'd0), .InstrValid(valid_b), .InstrOut(out_b),
    .InstrPC(pc_b), .InstrPCPlus4(pc4_b), .InstrAccept(1'b1),
    .RedirectValid(redir_b), .PCSrc(2'b11), .PCTarget(32'h0000_0200), .ALUResult(32'h0000_0204),
    .MisalignTrap(trap_b)
  );

  // Memory model: grant always, data one cycle after grant unless rv_en holds it back.
  initial forever begin
    @(negedge CLK);
    #1;
    IMemRValid = pend && rv_en;
    IMemRData  = IMemRValid ? (paddr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    if (IMemRValid) pend = 1'b0;
    if (IMemReq) begin
      pend  = 1'b1;
      paddr = IMemAddr;
    end
  end

  initial forever begin
    @(negedge CLK);
    #1;
    rv_b = gr_b;
    gr_b = req_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int exp_cyc);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!InstrValid && n < 20);
    chk({tag, "_lat"}, n, exp_cyc);
  endtask

  initial begin
    @(negedge CLK);
    chk("rst_req", IMemReq, 0);
    chk("rst_addr", IMemAddr, 32'h0);
    chk("rst_valid", InstrValid, 0);
    chk("rst_out", InstrOut, 32'h0);
    chk("rst_pc", InstrPC, 32'h0);
    chk("rst_pc4", InstrPCPlus4, 32'h4);
    chk("rst_trap", MisalignTrap, 0);
    ResetN = 1'b1;
    wait_valid("v0", 3);
    chk("v0_pc", InstrPC, 32'h0);
    chk("v0_pc4", InstrPCPlus4, 32'h4);
    chk("v0_out", InstrOut, 32'hA5A5_0000);
    wait_valid("v1", 3);
    chk("v1_pc", InstrPC, 32'h4);
    chk("v1_pc4", InstrPCPlus4, 32'h8);
    wait_valid("v2", 3);
    chk("v2_pc", InstrPC, 32'h8);
    InstrAccept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("hold_valid", InstrValid, 1);
      chk("hold_pc", InstrPC, 32'h8);
      chk("hold_out", InstrOut, 32'hA5A5_0008);
      chk("hold_req", IMemReq, 0);
    end
    InstrAccept = 1'b1;
    @(negedge CLK);
    chk("acc_req", IMemReq, 1);
    chk("acc_addr", IMemAddr, 32'hC);
    rv_en = 1'b0;
    @(negedge CLK);
    RedirectValid = 1'b1;
    PCSrc = 2'b01;
    PCTarget = 32'h0000_0040;
    @(negedge CLK);
    chk("kill_addr", IMemAddr, 32'h40);
    chk("kill_req", IMemReq, 0);
    chk("kill_valid", InstrValid, 0);
    RedirectValid = 1'b0;
    rv_en = 1'b1;
    @(negedge CLK);
    chk("kill_drop", InstrValid, 0);
    chk("kill_req2", IMemReq, 1);
    chk("kill_addr2", IMemAddr, 32'h40);
    wait_valid("v40", 2);
    chk("v40_pc", InstrPC, 32'h40);
    chk("v40_out", InstrOut, 32'hA5A5_0040);
    @(negedge CLK);
    chk("seq_addr", IMemAddr, 32'h44);
    RedirectValid = 1'b1;
    PCSrc = 2'b10;
    ALUResult = 32'h0000_0042;
    @(negedge CLK);
    chk("trap_pulse", MisalignTrap, 1);
    chk("trap_addr", IMemAddr, 32'h100);
    chk("trap_req", IMemReq, 0);
    RedirectValid = 1'b0;
    @(negedge CLK);
    chk("trap_end", MisalignTrap, 0);
    chk("trap_req2", IMemReq, 1);
    chk("trap_addr2", IMemAddr, 32'h100);
    wait_valid("vtrap", 2);
    chk("vtrap_pc", InstrPC, 32'h100);
    RedirectValid = 1'b1;
    PCSrc = 2'b01;
    PCTarget = 32'h0000_0080;
    @(negedge CLK);
    chk("hold_redir_valid", InstrValid, 0);
    chk("hold_redir_addr", IMemAddr, 32'h80);
    chk("hold_redir_req", IMemReq, 1);
    RedirectValid = 1'b0;
    rv_en = 1'b0;
    @(negedge CLK);
    ResetN = 1'b0;
    @(negedge CLK);
    chk("mrst_req", IMemReq, 0);
    chk("mrst_addr", IMemAddr, 32'h0);
    chk("mrst_valid", InstrValid, 0);
    chk("mrst_out", InstrOut, 32'h0);
    chk("mrst_pc4", InstrPCPlus4, 32'h4);
    rv_en = 1'b1;
    ResetN = 1'b1;
    @(negedge CLK);
    chk("mrst_late", InstrValid, 0);
    chk("mrst_req2", IMemReq, 1);
    chk("mrst_addr2", IMemAddr, 32'h0);
    wait_valid("vrst", 2);
    chk("vrst_pc", InstrPC, 32'h0);
    chk("vrst_out", InstrOut, 32'hA5A5_0000);

    @(negedge CLK);
    rst_b_n = 1'b1;
    redir_b = 1'b1;
    @(negedge CLK);
    chk("wrap_req", req_b, 1);
    chk("wrap_addr", addr_b, 32'hFFFF_FFFC);
    begin
      int n = 0;
      while (!valid_b && n < 10) begin
        @(negedge CLK);
        n++;
      end
      chk("wrap_valid", valid_b, 1);
      chk("wrap_pc", pc_b, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc4_b, 32'h0);
      n = 0;
      while (!req_b && n < 10) begin
        @(negedge CLK);
        n++;
      end
      chk("wrap_req2", req_b, 1);
      chk("wrap_addr2", addr_b, 32'h0);
      chk("wrap_trap", trap_b, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
